// File: rtl/lfsr_galois_run.sv
// -----------------------------------------------------------------------------
// lfsr_galois_run
//   Parametrised Galois LFSR with single-step and burst-run control.
//
// Ports:
//   clk      in   1      system clock, all state changes on the rising edge
//   rst_n    in   1      asynchronous active-low reset
//   seed     in   WIDTH  value written by load
//   load     in   1      load seed (highest priority, aborts any burst)
//   shift    in   1      single step, honoured only in IDLE
//   start    in   1      begin a burst of `steps` shifts (IDLE or DONE only)
//   steps    in   CNT_W  burst length, sampled on the accepted start
//   result   out  WIDTH  current register value
//   sout     out  1      serial output, MSB of the register
//   busy     out  1      high while the burst engine is running
//   done     out  1      one-cycle pulse marking burst completion
//   seed_err out  1      (LFSR_ZERO_GUARD_EN only) pulse after a zero-seed load
//
// Optional feature macro: LFSR_ZERO_GUARD_EN
//   Defined   : a zero seed is replaced by RESET_SEED and seed_err pulses.
//   Undefined : a zero seed is loaded as-is (the register locks up at zero).
// -----------------------------------------------------------------------------

// Purpose: Galois LFSR stepped singly or in counted bursts.
// Latency: a step lands on the edge it is requested; a burst accepted at edge k shifts on k+1..k+N, done the cycle after.
// Backpressure: none; start/shift outside their legal states are dropped, load always wins.
module lfsr_galois_run #(
  parameter int                 WIDTH      = 8,
  parameter logic [WIDTH-1:0]   TAPS       = 8'h71,
  parameter logic [WIDTH-1:0]   RESET_SEED = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int                 CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  seed,
  input  logic              load,
  input  logic              shift,
  input  logic              start,
  input  logic [CNT_W-1:0]  steps,
  output logic [WIDTH-1:0]  result,
  output logic              sout,
  output logic              busy,
`ifdef LFSR_ZERO_GUARD_EN
  output logic              done,
  output logic              seed_err
`else
  output logic              done
`endif
);

  // ---------------------------------------------------------------------------
  // Burst engine states
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_nxt;
  logic [1:0]       state_q;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0] lfsr_step;
  logic [WIDTH-1:0] load_val;
  logic             start_ok;

  // One Galois step: shift left, fold the taps back in when the MSB falls out.
  assign lfsr_step = {lfsr_q[WIDTH-2:0], 1'b0} ^ (lfsr_q[WIDTH-1] ? TAPS : '0);

`ifdef LFSR_ZERO_GUARD_EN
  logic seed_zero;
  logic seed_err_q;

  // A zero seed would lock the register up, so substitute the reset seed.
  assign seed_zero = (seed == '0);
  assign load_val  = seed_zero ? RESET_SEED : seed;
`else
  assign load_val  = seed;
`endif

  // start is only accepted when the engine is not mid-burst.
  assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);

  // ---------------------------------------------------------------------------
  // Next-state logic (load > start > shift)
  // ---------------------------------------------------------------------------
  always_comb begin
    lfsr_nxt  = lfsr_q;
    state_nxt = state_q;
    cnt_nxt   = cnt_q;

    if (load) begin
      lfsr_nxt  = load_val;
      state_nxt = ST_IDLE;
      cnt_nxt   = CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            // The accepting edge never shifts; the burst begins on the next one.
            if (steps != CNT_ZERO) begin
              cnt_nxt   = steps;
              state_nxt = ST_RUN;
            end else begin
              state_nxt = ST_DONE;
            end
          end else if (shift) begin
            lfsr_nxt = lfsr_step;
          end
        end

        ST_RUN: begin
          lfsr_nxt = lfsr_step;
          cnt_nxt  = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_nxt = ST_DONE;
          end
        end

        ST_DONE: begin
          // Back-to-back bursts: a start here re-arms directly; shift is dropped.
          if (start_ok) begin
            if (steps != CNT_ZERO) begin
              cnt_nxt   = steps;
              state_nxt = ST_RUN;
            end else begin
              state_nxt = ST_DONE;
            end
          end else begin
            state_nxt = ST_IDLE;
          end
        end

        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = CNT_ZERO;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q  <= RESET_SEED;
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      lfsr_q  <= lfsr_nxt;
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

`ifdef LFSR_ZERO_GUARD_EN
  // Pulses for exactly the cycle following a zero-seed load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_err_q <= 1'b0;
    end else begin
      seed_err_q <= load && seed_zero;
    end
  end

  assign seed_err = seed_err_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs: decoded straight from registers, so they are glitch-free.
  // ---------------------------------------------------------------------------
  assign result = lfsr_q;
  assign sout   = lfsr_q[WIDTH-1];
  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);

endmodule
